// File: rtl/data_mem_pkg.sv
// Shared constants and types for the data-memory arbiter slice.
package data_mem_pkg;

  localparam int MEM_DEPTH  = 256;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } port_id_t;

  // Response bookkeeping captured at grant, consumed one cycle later.
  typedef struct packed {
    logic     vld;
    port_id_t port;
    logic     is_read;
    logic     oob;
  } rsp_t;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin pick plus the last-grant register.
// No grant is produced while reset is asserted.
module rr_arb2
  import data_mem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output port_id_t   gnt_port_o
);

  port_id_t last_q;

  always_comb begin
    gnt_o      = 2'b00;
    gnt_port_o = PORT_CPU;
    if (rst_ni) begin
      case (req_i)
        2'b01: begin
          gnt_o      = 2'b01;
          gnt_port_o = PORT_CPU;
        end
        2'b10: begin
          gnt_o      = 2'b10;
          gnt_port_o = PORT_DMA;
        end
        2'b11: begin
          // Conflict: the port that did not win last time goes now.
          if (last_q == PORT_CPU) begin
            gnt_o      = 2'b10;
            gnt_port_o = PORT_DMA;
          end else begin
            gnt_o      = 2'b01;
            gnt_port_o = PORT_CPU;
          end
        end
        default: begin
          gnt_o      = 2'b00;
          gnt_port_o = PORT_CPU;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)      last_q <= PORT_DMA;
    else if (|gnt_o)  last_q <= gnt_port_o;
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin front end for the single-port data memory.
// Optional DATA_MEM_ARB_BOUNDS_CHECK_EN: out-of-range commands are granted but suppressed and flagged on Err.
module data_mem_arbiter
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int DEPTH  = MEM_DEPTH
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Req0,
  input  logic              We0,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [DATA_W-1:0] WData0,
  output logic              Gnt0,
  output logic              RspValid0,
  output logic [DATA_W-1:0] RData0,
  input  logic              Req1,
  input  logic              We1,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData1,
  output logic              Gnt1,
  output logic              RspValid1,
  output logic [DATA_W-1:0] RData1,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [DATA_W-1:0] Mem_WriteData,
  output logic              Mem_MemWrite,
  output logic              Mem_MemRead,
  input  logic [DATA_W-1:0] Mem_ReadData,
  output logic              Err
);

  localparam int NUM_PORTS = 2;

  logic [NUM_PORTS-1:0]             req, gnt, we;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wdata;
  port_id_t                         gnt_port;
  logic                             gnt_any, we_sel, oob;
  logic [ADDR_W-1:0]                addr_sel;
  logic [DATA_W-1:0]                wdata_sel, rd_val;
  rsp_t                             rsp_d, rsp_q;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_d, rdata_q;

  assign req   = {Req1, Req0};
  assign we    = {We1, We0};
  assign addr  = {Addr1, Addr0};
  assign wdata = {WData1, WData0};

  rr_arb2 u_arb (
    .clk_i      (Clk),
    .rst_ni     (Reset_n),
    .req_i      (req),
    .gnt_o      (gnt),
    .gnt_port_o (gnt_port)
  );

  assign Gnt0      = gnt[0];
  assign Gnt1      = gnt[1];
  assign gnt_any   = |gnt;
  assign addr_sel  = addr[gnt_port];
  assign wdata_sel = wdata[gnt_port];
  assign we_sel    = we[gnt_port];

`ifdef DATA_MEM_ARB_BOUNDS_CHECK_EN
  assign oob = gnt_any && (addr_sel >= ADDR_W'(DEPTH));
  assign Err = Reset_n & rsp_q.vld & rsp_q.oob;
`else
  logic unused_depth;
  assign unused_depth = (addr_sel >= ADDR_W'(DEPTH));
  assign oob = 1'b0;
  assign Err = 1'b0;
`endif

  // Address/data are zeroed when idle so the memory bus is quiet.
  assign Mem_Address   = gnt_any ? addr_sel  : '0;
  assign Mem_WriteData = gnt_any ? wdata_sel : '0;
  assign Mem_MemWrite  = gnt_any &  we_sel & ~oob;
  assign Mem_MemRead   = gnt_any & ~we_sel & ~oob;

  always_comb begin
    rsp_d         = '0;
    rsp_d.vld     = gnt_any;
    rsp_d.port    = gnt_port;
    rsp_d.is_read = ~we_sel;
    rsp_d.oob     = oob;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) rsp_q <= '0;
    else          rsp_q <= rsp_d;
  end

  // Read data passes straight through in the response cycle; writes leave RData holding.
  assign rd_val = rsp_q.oob ? '0 : Mem_ReadData;

  always_comb begin
    rdata_d = rdata_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rsp_q.vld && rsp_q.is_read && (rsp_q.port == ((p == 0) ? PORT_CPU : PORT_DMA)))
        rdata_d[p] = rd_val;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign RspValid0 = Reset_n & rsp_q.vld & (rsp_q.port == PORT_CPU);
  assign RspValid1 = Reset_n & rsp_q.vld & (rsp_q.port == PORT_DMA);
  assign RData0    = Reset_n ? rdata_d[0] : '0;
  assign RData1    = Reset_n ? rdata_d[1] : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a registered 256x32 memory model.
// Honours DATA_MEM_ARB_BOUNDS_CHECK_EN for the bounds scenario.
module tb_data_mem_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Req0, We0, Req1, We1;
  logic [31:0] Addr0, WData0, Addr1, WData1;
  logic        Gnt0, Gnt1, RspValid0, RspValid1;
  logic [31:0] RData0, RData1;
  logic [31:0] Mem_Address, Mem_WriteData, Mem_ReadData;
  logic        Mem_MemWrite, Mem_MemRead, Err;

  int errors = 0;
  int checks = 0;

  // Memory model, with a backdoor load port used only while the DUT is held in reset.
  logic [31:0] mem [0:255];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (Mem_MemWrite && Mem_Address < 32'd256) mem[Mem_Address[7:0]] <= Mem_WriteData;
    if (Mem_MemRead) Mem_ReadData <= (Mem_Address < 32'd256) ? mem[Mem_Address[7:0]] : 32'h0;
  end

  data_mem_arbiter dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .Req0(Req0), .We0(We0), .Addr0(Addr0), .WData0(WData0),
    .Gnt0(Gnt0), .RspValid0(RspValid0), .RData0(RData0),
    .Req1(Req1), .We1(We1), .Addr1(Addr1), .WData1(WData1),
    .Gnt1(Gnt1), .RspValid1(RspValid1), .RData1(RData1),
    .Mem_Address(Mem_Address), .Mem_WriteData(Mem_WriteData),
    .Mem_MemWrite(Mem_MemWrite), .Mem_MemRead(Mem_MemRead),
    .Mem_ReadData(Mem_ReadData), .Err(Err)
  );

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle;
    Req0 = 1'b0; We0 = 1'b0; Addr0 = '0; WData0 = '0;
    Req1 = 1'b0; We1 = 1'b0; Addr1 = '0; WData1 = '0;
  endtask

  task automatic do_reset;
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
  endtask

  task automatic test_reset;
    logic [7:0]  la [10];
    logic [31:0] ld [10];
    la = '{8'd1, 8'd2, 8'd5, 8'd10, 8'd20, 8'd21, 8'd22, 8'd23, 8'd44, 8'd0};
    ld = '{32'hA1A10001, 32'hB2B20002, 32'hDEADBEEF, 32'h0BAD000A, 32'hC0DE0020,
           32'hC0DE0021, 32'hC0DE0022, 32'hC0DE0023, 32'h44440044, 32'h0};
    Reset_n = 1'b0;
    idle();
    Req0 = 1'b1; Addr0 = 32'd5; Req1 = 1'b1; Addr1 = 32'd2;
    for (int i = 0; i < 10; i++) begin
      bd_we = 1'b1; bd_addr = la[i]; bd_data = ld[i];
      tick();
    end
    bd_we = 1'b0;
    #1;
    checks++; if (Gnt0 !== 1'b0 || Gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b%b expected 00", Gnt1, Gnt0); end
    checks++; if (RspValid0 !== 1'b0 || RspValid1 !== 1'b0) begin errors++; $display("FAIL reset_rspvalid: got %b%b expected 00", RspValid1, RspValid0); end
    checks++; if (Mem_MemWrite !== 1'b0 || Mem_MemRead !== 1'b0) begin errors++; $display("FAIL reset_memctl: got w%b r%b expected 0 0", Mem_MemWrite, Mem_MemRead); end
    checks++; if (RData0 !== 32'h0 || RData1 !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h %h expected 0 0", RData0, RData1); end
    checks++; if (Err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", Err); end
    idle();
    tick();
    Reset_n = 1'b1;
  endtask

  task automatic test_single_read;
    Req0 = 1'b1; We0 = 1'b0; Addr0 = 32'd5;
    #1;
    checks++; if (Gnt0 !== 1'b1 || Gnt1 !== 1'b0) begin errors++; $display("FAIL single_gnt: got %b%b expected 01", Gnt1, Gnt0); end
    checks++; if (Mem_MemRead !== 1'b1 || Mem_MemWrite !== 1'b0 || Mem_Address !== 32'd5) begin errors++; $display("FAIL single_issue: got r%b w%b a%h expected r1 w0 a5", Mem_MemRead, Mem_MemWrite, Mem_Address); end
    tick();
    Req0 = 1'b0;
    #1;
    checks++; if (RspValid0 !== 1'b1 || RspValid1 !== 1'b0) begin errors++; $display("FAIL single_rsp: got %b%b expected 01", RspValid1, RspValid0); end
    checks++; if (RData0 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata: got %h expected deadbeef", RData0); end
    checks++; if (Gnt0 !== 1'b0 || Mem_MemRead !== 1'b0) begin errors++; $display("FAIL single_idle: got g%b r%b expected 0 0", Gnt0, Mem_MemRead); end
    tick();
  endtask

  task automatic test_alternate;
    logic [31:0] exp_d;
    int g, pv;
    do_reset();
    Req0 = 1'b1; We0 = 1'b0; Addr0 = 32'd1;
    Req1 = 1'b1; We1 = 1'b0; Addr1 = 32'd2;
    for (int i = 0; i < 6; i++) begin
      #1;
      g = i % 2;
      checks++; if (Gnt0 !== (g == 0) || Gnt1 !== (g == 1)) begin errors++; $display("FAIL alt_gnt%0d: got %b%b expected port %0d", i, Gnt1, Gnt0, g); end
      if (i > 0) begin
        pv = (i - 1) % 2;
        exp_d = (pv == 0) ? 32'hA1A10001 : 32'hB2B20002;
        checks++;
        if (RspValid0 !== (pv == 0) || RspValid1 !== (pv == 1) || ((pv == 0) ? RData0 : RData1) !== exp_d) begin
          errors++; $display("FAIL alt_rsp%0d: got v%b%b d0=%h d1=%h expected port %0d data %h", i, RspValid1, RspValid0, RData0, RData1, pv, exp_d);
        end
      end
      tick();
    end
    idle();
    #1;
    checks++; if (RspValid1 !== 1'b1 || RspValid0 !== 1'b0 || RData1 !== 32'hB2B20002) begin errors++; $display("FAIL alt_last: got v%b%b d1=%h expected port 1 b2b20002", RspValid1, RspValid0, RData1); end
    tick();
  endtask

  task automatic test_write_then_read;
    Req1 = 1'b1; We1 = 1'b1; Addr1 = 32'd10; WData1 = 32'h12345678;
    #1;
    checks++; if (Gnt1 !== 1'b1 || Mem_MemWrite !== 1'b1 || Mem_MemRead !== 1'b0 || Mem_Address !== 32'd10 || Mem_WriteData !== 32'h12345678) begin
      errors++; $display("FAIL wr_issue: got g%b w%b r%b a%h d%h expected 1 1 0 a 12345678", Gnt1, Mem_MemWrite, Mem_MemRead, Mem_Address, Mem_WriteData);
    end
    tick();
    idle();
    Req0 = 1'b1; We0 = 1'b0; Addr0 = 32'd10;
    #1;
    checks++; if (Gnt0 !== 1'b1 || RspValid1 !== 1'b1) begin errors++; $display("FAIL wr_rsp: got g0=%b v1=%b expected 1 1", Gnt0, RspValid1); end
    checks++; if (RData1 !== 32'hB2B20002) begin errors++; $display("FAIL wr_hold: got %h expected b2b20002", RData1); end
    tick();
    idle();
    #1;
    checks++; if (RspValid0 !== 1'b1 || RData0 !== 32'h12345678) begin errors++; $display("FAIL raw_rdata: got v%b %h expected 1 12345678", RspValid0, RData0); end
    tick();
  endtask

  task automatic test_mid_reset;
    Req1 = 1'b1; We1 = 1'b0; Addr1 = 32'd2;
    #1;
    checks++; if (Gnt1 !== 1'b1) begin errors++; $display("FAIL mrst_gnt1: got %b expected 1", Gnt1); end
    tick();
    idle();
    Reset_n = 1'b0;
    Req0 = 1'b1; Addr0 = 32'd1;
    #1;
    checks++; if (RspValid1 !== 1'b0 || RspValid0 !== 1'b0) begin errors++; $display("FAIL mrst_norsp: got %b%b expected 00", RspValid1, RspValid0); end
    checks++; if (Gnt0 !== 1'b0 || Mem_MemRead !== 1'b0) begin errors++; $display("FAIL mrst_nognt: got g%b r%b expected 0 0", Gnt0, Mem_MemRead); end
    checks++; if (RData0 !== 32'h0 || RData1 !== 32'h0) begin errors++; $display("FAIL mrst_rdata: got %h %h expected 0 0", RData0, RData1); end
    tick();
    Reset_n = 1'b1;
    Req0 = 1'b1; We0 = 1'b0; Addr0 = 32'd1;
    Req1 = 1'b1; We1 = 1'b0; Addr1 = 32'd2;
    #1;
    checks++; if (Gnt0 !== 1'b1 || Gnt1 !== 1'b0) begin errors++; $display("FAIL mrst_first: got %b%b expected 01", Gnt1, Gnt0); end
    checks++; if (RspValid0 !== 1'b0 || RspValid1 !== 1'b0 || RData0 !== 32'h0 || RData1 !== 32'h0) begin
      errors++; $display("FAIL mrst_clean: got v%b%b %h %h expected 00 0 0", RspValid1, RspValid0, RData0, RData1);
    end
    tick();
    idle();
    #1;
    checks++; if (RspValid0 !== 1'b1 || RData0 !== 32'hA1A10001) begin errors++; $display("FAIL mrst_after: got v%b %h expected 1 a1a10001", RspValid0, RData0); end
    tick();
  endtask

  task automatic test_bounds;
`ifdef DATA_MEM_ARB_BOUNDS_CHECK_EN
    Req0 = 1'b1; We0 = 1'b1; Addr0 = 32'd300; WData0 = 32'hFFFFFFFF;
    #1;
    checks++; if (Gnt0 !== 1'b1 || Mem_MemWrite !== 1'b0 || Mem_MemRead !== 1'b0) begin errors++; $display("FAIL oob_wr_issue: got g%b w%b r%b expected 1 0 0", Gnt0, Mem_MemWrite, Mem_MemRead); end
    tick();
    We0 = 1'b0;
    #1;
    checks++; if (RspValid0 !== 1'b1 || Err !== 1'b1) begin errors++; $display("FAIL oob_wr_err: got v%b e%b expected 1 1", RspValid0, Err); end
    checks++; if (Gnt0 !== 1'b1 || Mem_MemRead !== 1'b0) begin errors++; $display("FAIL oob_rd_issue: got g%b r%b expected 1 0", Gnt0, Mem_MemRead); end
    tick();
    Addr0 = 32'd44;
    #1;
    checks++; if (RspValid0 !== 1'b1 || Err !== 1'b1 || RData0 !== 32'h0) begin errors++; $display("FAIL oob_rd_rsp: got v%b e%b %h expected 1 1 0", RspValid0, Err, RData0); end
    tick();
    idle();
    #1;
    checks++; if (RspValid0 !== 1'b1 || Err !== 1'b0 || RData0 !== 32'h44440044) begin errors++; $display("FAIL oob_mem_kept: got v%b e%b %h expected 1 0 44440044", RspValid0, Err, RData0); end
    tick();
`else
    Req0 = 1'b1; We0 = 1'b1; Addr0 = 32'd300; WData0 = 32'hFFFFFFFF;
    #1;
    checks++; if (Gnt0 !== 1'b1 || Mem_MemWrite !== 1'b1 || Mem_Address !== 32'd300) begin errors++; $display("FAIL nochk_issue: got g%b w%b a%h expected 1 1 12c", Gnt0, Mem_MemWrite, Mem_Address); end
    tick();
    idle();
    #1;
    checks++; if (RspValid0 !== 1'b1 || Err !== 1'b0) begin errors++; $display("FAIL nochk_rsp: got v%b e%b expected 1 0", RspValid0, Err); end
    tick();
`endif
  endtask

  task automatic test_back_to_back;
    int pulses = 0;
    Req1 = 1'b1; We1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      Addr1 = 32'd20 + i;
      #1;
      checks++; if (Gnt1 !== 1'b1 || Gnt0 !== 1'b0 || Mem_MemRead !== 1'b1) begin errors++; $display("FAIL b2b_issue%0d: got g%b%b r%b expected 10 1", i, Gnt1, Gnt0, Mem_MemRead); end
      if (RspValid1 === 1'b1) pulses++;
      if (i > 0) begin
        checks++; if (RspValid1 !== 1'b1 || RData1 !== (32'hC0DE0020 + i - 1)) begin errors++; $display("FAIL b2b_rsp%0d: got v%b %h expected 1 %h", i, RspValid1, RData1, 32'hC0DE0020 + i - 1); end
      end
      tick();
    end
    idle();
    #1;
    if (RspValid1 === 1'b1) pulses++;
    checks++; if (RData1 !== 32'hC0DE0023 || Mem_MemRead !== 1'b0) begin errors++; $display("FAIL b2b_last: got %h r%b expected c0de0023 0", RData1, Mem_MemRead); end
    checks++; if (pulses != 4) begin errors++; $display("FAIL b2b_pulses: got %0d expected 4", pulses); end
    tick();
    #1;
    checks++; if (RspValid1 !== 1'b0) begin errors++; $display("FAIL b2b_quiet: got %b expected 0", RspValid1); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_alternate();
    test_write_then_read();
    test_mid_reset();
    test_bounds();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the single-port 256x32 data memory.
- Memory read data is registered, so reads have 1-cycle latency.
- Port 0 is the CPU load/store unit; port 1 is the DMA/debug loader.
- Sole owner of the memory's address, writeData, MemWrite and MemRead inputs; routes ReadData back to the granted requester.

Parameters:
ADDR_W, 32, address width of requester and memory buses
DATA_W, 32, data width
DEPTH, 256, number of memory words; used by bounds check

Ports:
Clk  in  1  system clock, all logic on posedge
Reset_n  in  1  synchronous active-low reset, sampled on posedge Clk
Req0  in  1  port 0 request; held with Addr0/We0/WData0 until Gnt0
We0  in  1  port 0 write enable (1 = write, 0 = read)
Addr0  in  ADDR_W  port 0 word address
WData0  in  DATA_W  port 0 write data
Gnt0  out  1  port 0 command accepted this cycle (combinational)
RspValid0  out  1  port 0 response pulse, 1 cycle after Gnt0
RData0  out  DATA_W  port 0 read data, valid with RspValid0 for reads
Req1, We1, Addr1, WData1, Gnt1, RspValid1, RData1  same as port 0, for port 1
Mem_Address  out  ADDR_W  to memory address
Mem_WriteData  out  DATA_W  to memory writeData
Mem_MemWrite  out  1  to memory MemWrite
Mem_MemRead  out  1  to memory MemRead
Mem_ReadData  in  DATA_W  from memory ReadData (registered, valid cycle after command)
Err  out  1  bounds error pulse (see Optional Feature; tied 0 when disabled)

Behaviour:
- One clock (Clk). Reset is synchronous and active-low (Reset_n).
- Reset values while Reset_n=0:
  - Gnt0/1, RspValid0/1, Mem_MemWrite, Mem_MemRead, Err: 0.
  - RData0/1: 0.
  - last_grant: 1, so port 0 wins the first conflict.
  - Response pipeline registers: cleared.
- Arbitration, combinational each cycle when Reset_n=1:
  - Only one Req high: grant that port.
  - Both high: grant the port != last_grant.
  - last_grant updates on every grant.
  - Exactly one Gnt is high at most.
- Issue cycle: Mem_* driven from the granted port. Mem_MemWrite=We, Mem_MemRead=~We. With no grant, Mem_MemWrite=Mem_MemRead=0 and address/data are don't-care (drive 0).
- Response: registered rsp_port and rsp_is_read are captured at the grant. In the next cycle:
  - RspValid[rsp_port] pulses for one cycle.
  - For reads, RData[rsp_port] = Mem_ReadData.
  - For writes, RData holds its previous value.
- Throughput: a new grant is allowed every cycle. The response of cycle N overlaps the issue of cycle N+1, so one transaction completes per cycle.
- Ordering and hazards:
  - A write at N followed by a read of the same address at N+1 returns the new data.
  - Memory write and read-out are the same posedge, so no same-cycle hazard exists across ports.
- Requester rule: Req, We, Addr and WData stay stable until Gnt. Req may drop only after Gnt. A requester may keep Req high for back-to-back operations.
- Mid-operation reset: any pending response is dropped with no RspValid, and no grant is issued in the reset cycle.

Optional Feature:
- Macro: DATA_MEM_ARB_BOUNDS_CHECK_EN.
- Defined:
  - A granted command with Addr >= DEPTH is still granted, but Mem_MemWrite and Mem_MemRead are forced to 0.
  - Next cycle: RspValid pulses, RData = 0 for reads, and Err pulses high for one cycle together with it.
- Undefined: no check, full address forwarded, Err tied 0.

Decomposition:
- Package data_mem_pkg holds:
  - Constants MEM_DEPTH=256, MEM_ADDR_W=32, MEM_DATA_W=32.
  - Typedef port_id_t (1 bit): PORT_CPU=0, PORT_DMA=1.
- One sub-module, rr_arb2: combinational 2-way round-robin pick from Req and last_grant, plus the last_grant register.

Test Plan:
1. Reset, then Req0 read Addr=5 (mem[5]=0xDEADBEEF) -> Gnt0 at cycle 1; RspValid0=1, RData0=0xDEADBEEF at cycle 2; no port-1 activity.
2. Req0 and Req1 both continuous reads for 6 cycles -> grants alternate 0,1,0,1,0,1; each response lands on the correct port with correct data.
3. Port 1 writes 0x12345678 to Addr=10, then port 0 reads Addr=10 in the next cycle -> RData0=0x12345678.
4. Reset_n=0 in the cycle after Gnt1 for a read -> no RspValid1; after release, outputs are 0 and the first conflict grants port 0.
5. With DATA_MEM_ARB_BOUNDS_CHECK_EN, Req0 writes Addr=300 -> Gnt0=1, Mem_MemWrite=0; next cycle RspValid0=1, Err=1; memory unchanged.
6. Req1 held 4 cycles alone -> Gnt1 every cycle, 4 RspValid1 pulses, Mem_MemRead=1 for 4 cycles.
